// File: rtl/case_7_div_pkg.sv
// Shared types and helpers for the case_7 sequential signed divider.
// Holds the FSM state encoding and the counter width helper.
package case_7_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/case_7_sdiv_step.sv
// One restoring-division iteration on magnitudes; purely combinational, zero latency.
// No flow control: the caller decides when the result is registered.
module case_7_sdiv_step #(
    parameter int W = 5
) (
    input  logic [W:0]   prem,
    input  logic         dvd_bit,
    input  logic [W-1:0] dvs,
    output logic [W:0]   prem_next,
    output logic         q_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted   = {prem, dvd_bit};
        q_bit     = (shifted >= {2'b00, dvs});
        diff      = shifted - {2'b00, dvs};
        // The partial remainder stays below the divisor, so the top bit always drops off.
        prem_next = (W+1)'(q_bit ? diff : shifted);
    end

endmodule

// File: rtl/case_7_sdiv_seq_10s_5s_10.sv
// Iterative signed divider (C truncation); done pulses din0_WIDTH+1 cycles after accept.
// ready is low while busy, start is dropped then; ce=0 freezes all state and stretches latency.
module case_7_sdiv_seq_10s_5s_10
    import case_7_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    localparam int CNT_W = clog2(din0_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(din0_WIDTH - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [din0_WIDTH-1:0]   dvd;
    logic [din1_WIDTH-1:0]   dvs;
    logic [din1_WIDTH:0]     prem;
    logic                    neg_q;
    logic                    neg_r;
    logic                    dvs_zero;

    logic [din1_WIDTH:0]     prem_next;
    logic                    q_bit;
    logic [din0_WIDTH-1:0]   q_mag;
    logic [din1_WIDTH-1:0]   r_mag;
    logic [dout_WIDTH-1:0]   quot_fix;
    logic [din1_WIDTH-1:0]   rem_fix;
    logic [din0_WIDTH-1:0]   din0_mag;
    logic [din1_WIDTH-1:0]   din1_mag;

    case_7_sdiv_step #(.W(din1_WIDTH)) u_step (
        .prem      (prem),
        .dvd_bit   (dvd[din0_WIDTH-1]),
        .dvs       (dvs),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    always_comb begin
        din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;
        din1_mag = din1[din1_WIDTH-1] ? -din1 : din1;
        // Quotient bits enter at the LSB as dividend bits leave at the MSB.
        q_mag    = {dvd[din0_WIDTH-2:0], q_bit};
        r_mag    = din1_WIDTH'(prem_next);
        quot_fix = neg_q ? dout_WIDTH'(-q_mag) : dout_WIDTH'(q_mag);
        rem_fix  = neg_r ? -r_mag : r_mag;
        if (dvs_zero) begin
            quot_fix = '1;
            rem_fix  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dvs_zero    <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvd      <= din0_mag;
                        dvs      <= din1_mag;
                        neg_r    <= din0[din0_WIDTH-1];
                        neg_q    <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        dvs_zero <= (din1 == '0);
                        prem     <= '0;
                        cnt      <= '0;
                        ready    <= 1'b0;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    dvd  <= q_mag;
                    prem <= prem_next;
                    cnt  <= cnt + 1'b1;
                    // Final iteration: results are fixed up and registered together with done.
                    if (cnt == LAST_ITER) begin
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        quot        <= quot_fix;
                        rem         <= rem_fix;
                        div_by_zero <= dvs_zero;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case_7_sdiv_seq_10s_5s_10.sv
// Directed bench for the case_7 sequential signed divider.
module tb_case_7_sdiv_seq_10s_5s_10;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       start;
    logic [9:0] din0;
    logic [4:0] din1;
    logic       ready;
    logic       done;
    logic [9:0] quot;
    logic [4:0] rem;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    case_7_sdiv_seq_10s_5s_10 dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .start       (start),
        .din0        (din0),
        .din1        (din1),
        .ready       (ready),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    // Returns at the falling edge of cycle T+1; operands are scrambled after accept.
    task automatic issue(input logic [9:0] a, input logic [4:0] b);
        @(negedge clk);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din0  = ~a;
        din1  = ~b;
    endtask

    // lat = cycle offset from T at which done is seen; ready_hi counts busy cycles with ready high.
    task automatic wait_done(output int lat, output int ready_hi);
        lat      = 1;
        ready_hi = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (ready !== 1'b0) ready_hi++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (quot !== 10'd0) begin n_fail++; $display("FAIL reset_quot: got %h expected 000", quot); end
        n_tests++; if (rem !== 5'd0) begin n_fail++; $display("FAIL reset_rem: got %h expected 00", rem); end
        n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_basic();
        int lat, rh;
        issue(10'd100, 5'd7);
        wait_done(lat, rh);
        n_tests++; if (lat != 11) begin n_fail++; $display("FAIL basic_latency: got T+%0d expected T+11", lat); end
        n_tests++; if (rh != 0) begin n_fail++; $display("FAIL basic_ready_busy: ready high in %0d busy cycles expected 0", rh); end
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_done: got %b expected 0", ready); end
        n_tests++; if (quot !== 10'd14) begin n_fail++; $display("FAIL basic_quot: got %0d expected 14", $signed(quot)); end
        n_tests++; if (rem !== 5'd2) begin n_fail++; $display("FAIL basic_rem: got %0d expected 2", $signed(rem)); end
        n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
        // start presented in the done cycle must not be accepted
        start = 1'b1;
        din0  = 10'd1;
        din1  = 5'd1;
        @(negedge clk);
        start = 1'b0;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_start_in_done: ready got %b expected 1", ready); end
        n_tests++; if (quot !== 10'd14) begin n_fail++; $display("FAIL basic_quot_held: got %0d expected 14", $signed(quot)); end
    endtask

    task automatic test_signs();
        int a[6] = '{-100, 100, -100, -512, 511, 0};
        int b[6] = '{7, -7, -7, -1, -16, 5};
        int q[6] = '{-14, -14, 14, -512, -31, 0};
        int r[6] = '{-2, 2, -2, 0, 15, 0};
        for (int i = 0; i < 6; i++) begin
            int lat, rh;
            logic [9:0] eq;
            logic [4:0] er;
            eq = 10'(q[i]);
            er = 5'(r[i]);
            issue(10'(a[i]), 5'(b[i]));
            wait_done(lat, rh);
            n_tests++; if (lat != 11) begin n_fail++; $display("FAIL signs_latency[%0d]: got T+%0d expected T+11", i, lat); end
            n_tests++; if (quot !== eq) begin n_fail++; $display("FAIL signs_quot %0d/%0d: got %0d expected %0d", a[i], b[i], $signed(quot), q[i]); end
            n_tests++; if (rem !== er) begin n_fail++; $display("FAIL signs_rem %0d/%0d: got %0d expected %0d", a[i], b[i], $signed(rem), r[i]); end
            n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL signs_dbz[%0d]: got %b expected 0", i, div_by_zero); end
        end
    endtask

    task automatic test_div_zero();
        int lat, rh;
        issue(10'd37, 5'd0);
        wait_done(lat, rh);
        n_tests++; if (lat != 11) begin n_fail++; $display("FAIL dz_latency: got T+%0d expected T+11", lat); end
        n_tests++; if (quot !== 10'h3FF) begin n_fail++; $display("FAIL dz_quot: got %h expected 3ff", quot); end
        n_tests++; if (rem !== 5'd0) begin n_fail++; $display("FAIL dz_rem: got %h expected 00", rem); end
        n_tests++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
        issue(10'd37, 5'd5);
        wait_done(lat, rh);
        n_tests++; if (quot !== 10'd7) begin n_fail++; $display("FAIL dz_next_quot: got %0d expected 7", $signed(quot)); end
        n_tests++; if (rem !== 5'd2) begin n_fail++; $display("FAIL dz_next_rem: got %0d expected 2", $signed(rem)); end
        n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_flag_clear: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_reset_mid();
        int lat, rh, seen;
        issue(10'd100, 5'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if (quot !== 10'd0) begin n_fail++; $display("FAIL rmid_quot: got %h expected 000", quot); end
        n_tests++; if (rem !== 5'd0) begin n_fail++; $display("FAIL rmid_rem: got %h expected 00", rem); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", ready); end
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_done: done seen %0d times expected 0", seen); end
        issue(10'd9, 5'd2);
        wait_done(lat, rh);
        n_tests++; if (quot !== 10'd4) begin n_fail++; $display("FAIL rmid_next_quot: got %0d expected 4", $signed(quot)); end
        n_tests++; if (rem !== 5'd1) begin n_fail++; $display("FAIL rmid_next_rem: got %0d expected 1", $signed(rem)); end
    endtask

    task automatic test_stall();
        int lat, qi, ri;
        issue(10'd100, 5'd7);
        lat = 1;
        @(negedge clk); lat++;
        @(negedge clk); lat++;
        ce    = 1'b0;
        start = 1'b1;
        din0  = 10'd5;
        din1  = 5'd1;
        repeat (3) begin @(negedge clk); lat++; end
        ce = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        n_tests++; if (lat != 14) begin n_fail++; $display("FAIL stall_latency: got T+%0d expected T+14", lat); end
        n_tests++; if (quot !== 10'd14) begin n_fail++; $display("FAIL stall_quot: got %0d expected 14", $signed(quot)); end
        n_tests++; if (rem !== 5'd2) begin n_fail++; $display("FAIL stall_rem: got %0d expected 2", $signed(rem)); end
        qi = $signed(quot);
        ri = $signed(rem);
        n_tests++; if (qi * 7 + ri != 100 || ri >= 7 || ri <= -7) begin n_fail++; $display("FAIL stall_invariant: got q=%0d r=%0d for 100/7", qi, ri); end
        ce = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done_hold: got %b expected 1", done); end
        ce = 1'b1;
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done_clear: got %b expected 0", done); end
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready: got %b expected 1", ready); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_reset_mid();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
